zap_mult_operand_fetch: RTL and testbench

ZAP_MULT_OPERAND_FETCH -- requirements
Module: zap_mult_operand_fetch

---
 rtl/zap_mult_operand_fetch_if.sv | 46 ++++
 rtl/zap_mult_operand_fetch.sv | 97 +++++++++
 tb/tb_zap_mult_operand_fetch.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/zap_mult_operand_fetch_if.sv
// zap_mult_operand_fetch_if: pipeline, register-file and multiplier signals of the long-multiply operand fetch
interface zap_mult_operand_fetch_if #(
    parameter int PHY_REGS = 46,
    parameter int ALU_OPS  = 32
);
    localparam int IW = $clog2(PHY_REGS);
    localparam int OW = $clog2(ALU_OPS);
    logic          i_clear_from_writeback;
    logic          i_data_stall;
    logic          i_clear_from_alu;
    logic          i_valid;
    logic [OW-1:0] i_alu_operation;
    logic          i_cc_satisfied;
    logic          i_accumulate;
    logic [IW-1:0] i_rm_idx;
    logic [IW-1:0] i_rs_idx;
    logic [IW-1:0] i_rn_idx;
    logic [IW-1:0] i_rh_idx;
    logic [IW-1:0] o_rd_addr_a;
    logic [IW-1:0] o_rd_addr_b;
    logic [31:0]   i_rd_data_a;
    logic [31:0]   i_rd_data_b;
    logic [OW-1:0] o_alu_operation_ff;
    logic          o_cc_satisfied;
    logic [31:0]   o_rm;
    logic [31:0]   o_rs;
    logic [31:0]   o_rn;
    logic [31:0]   o_rh;
    logic          i_mult_busy;
    logic          o_busy;
    logic          o_done;
    modport slave (
        input  i_clear_from_writeback, i_data_stall, i_clear_from_alu, i_valid, i_alu_operation,
               i_cc_satisfied, i_accumulate, i_rm_idx, i_rs_idx, i_rn_idx, i_rh_idx,
               i_rd_data_a, i_rd_data_b, i_mult_busy,
        output o_rd_addr_a, o_rd_addr_b, o_alu_operation_ff, o_cc_satisfied,
               o_rm, o_rs, o_rn, o_rh, o_busy, o_done
    );
    modport master (
        output i_clear_from_writeback, i_data_stall, i_clear_from_alu, i_valid, i_alu_operation,
               i_cc_satisfied, i_accumulate, i_rm_idx, i_rs_idx, i_rn_idx, i_rh_idx,
               i_rd_data_a, i_rd_data_b, i_mult_busy,
        input  o_rd_addr_a, o_rd_addr_b, o_alu_operation_ff, o_cc_satisfied,
               o_rm, o_rs, o_rn, o_rh, o_busy, o_done
    );
endinterface

// File: rtl/zap_mult_operand_fetch.sv
// zap_mult_operand_fetch: reads the long-multiply operands over two register-file ports and sequences the multiplier
module zap_mult_operand_fetch #(
    parameter int PHY_REGS = 46,
    parameter int ALU_OPS  = 32
) (
    input logic                     i_clk,
    input logic                     i_reset,
    zap_mult_operand_fetch_if.slave bus
);
    localparam int IW = $clog2(PHY_REGS);
    localparam int OW = $clog2(ALU_OPS);
    localparam logic [OW-1:0] UMLALL = OW'(18);
    localparam logic [OW-1:0] UMLALH = OW'(19);
    localparam logic [OW-1:0] SMLALL = OW'(20);
    localparam logic [OW-1:0] SMLALH = OW'(21);
    typedef enum logic [2:0] {IDLE, RD_A, RD_B, CAP, ISSUE, WAIT} state_t;
    state_t        r_state;
    state_t        w_next;
    logic          r_acc;
    logic [IW-1:0] r_rm_idx;
    logic [IW-1:0] r_rs_idx;
    logic [IW-1:0] r_rn_idx;
    logic [IW-1:0] r_rh_idx;
    logic [OW-1:0] r_op;
    logic [31:0]   r_rm;
    logic [31:0]   r_rs;
    logic [31:0]   r_rn;
    logic [31:0]   r_rh;
    logic          w_is_mlal;
    logic          w_accept;
    logic          w_done;
    logic          w_flush;
    assign w_is_mlal = bus.i_alu_operation inside {UMLALL, UMLALH, SMLALL, SMLALH};
    assign w_accept  = r_state == IDLE && bus.i_valid && bus.i_cc_satisfied && w_is_mlal && !i_reset &&
                       !bus.i_clear_from_writeback && !bus.i_data_stall && !bus.i_clear_from_alu;
    assign w_done    = r_state == WAIT && !bus.i_mult_busy;
    assign w_flush   = i_reset || bus.i_clear_from_writeback || (!bus.i_data_stall && bus.i_clear_from_alu);
    assign bus.o_rd_addr_a        = r_state == RD_A ? r_rm_idx : (r_state == RD_B && r_acc) ? r_rn_idx : '0;
    assign bus.o_rd_addr_b        = r_state == RD_A ? r_rs_idx : (r_state == RD_B && r_acc) ? r_rh_idx : '0;
    assign bus.o_cc_satisfied     = r_state == ISSUE;
    assign bus.o_done             = w_done;
    assign bus.o_busy             = w_accept || (r_state != IDLE && !w_done);
    assign bus.o_alu_operation_ff = r_op;
    assign bus.o_rm               = r_rm;
    assign bus.o_rs               = r_rs;
    assign bus.o_rn               = r_rn;
    assign bus.o_rh               = r_rh;
    // Sequence: fetch rm/rs, optionally rn/rh, issue once, then wait for the multiplier to finish
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? RD_A : IDLE;
            RD_A:    w_next = RD_B;
            RD_B:    w_next = r_acc ? CAP : ISSUE;
            CAP:     w_next = ISSUE;
            ISSUE:   w_next = WAIT;
            WAIT:    w_next = bus.i_mult_busy ? WAIT : IDLE;
            default: w_next = IDLE;
        endcase
    end
    // Flushes zero everything, a stall freezes everything, otherwise latch the offer and capture read data
    always_ff @(posedge i_clk) begin
        if (w_flush) begin
            r_state  <= IDLE;
            r_acc    <= 1'b0;
            r_rm_idx <= '0;
            r_rs_idx <= '0;
            r_rn_idx <= '0;
            r_rh_idx <= '0;
            r_op     <= '0;
            r_rm     <= '0;
            r_rs     <= '0;
            r_rn     <= '0;
            r_rh     <= '0;
        end else if (!bus.i_data_stall) begin
            r_state <= w_next;
            if (w_accept) begin
                r_acc    <= bus.i_accumulate;
                r_rm_idx <= bus.i_rm_idx;
                r_rs_idx <= bus.i_rs_idx;
                r_rn_idx <= bus.i_rn_idx;
                r_rh_idx <= bus.i_rh_idx;
                r_op     <= bus.i_alu_operation;
            end
            if (r_state == RD_B) begin
                r_rm <= bus.i_rd_data_a;
                r_rs <= bus.i_rd_data_b;
                r_rn <= r_acc ? r_rn : '0;
                r_rh <= r_acc ? r_rh : '0;
            end
            if (r_state == CAP) begin
                r_rn <= bus.i_rd_data_a;
                r_rh <= bus.i_rd_data_b;
            end
        end
    end
endmodule

// File: tb/tb_zap_mult_operand_fetch.sv
// tb_zap_mult_operand_fetch: directed and random offers checked every cycle against a transaction-age reference model
module tb_zap_mult_operand_fetch;
    localparam int PHY_REGS = 46;
    localparam int ALU_OPS  = 32;
    localparam logic [4:0] UMLALL = 5'd18;
    localparam logic [4:0] UMLALH = 5'd19;
    localparam logic [4:0] SMLALL = 5'd20;
    localparam logic [4:0] SMLALH = 5'd21;
    localparam logic [4:0] MUL    = 5'd16;
    logic i_clk = 1'b0;
    logic i_reset = 1'b1;
    int errors = 0;
    int checks = 0;
    logic [31:0] regs [PHY_REGS];
    zap_mult_operand_fetch_if #(.PHY_REGS(PHY_REGS), .ALU_OPS(ALU_OPS)) bus ();
    zap_mult_operand_fetch #(.PHY_REGS(PHY_REGS), .ALU_OPS(ALU_OPS)) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .bus(bus)
    );
    always #5 i_clk = ~i_clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask
    // Register file: data one cycle after the address, frozen while the pipeline stalls
    always @(posedge i_clk) begin
        if (!bus.i_data_stall) begin
            bus.i_rd_data_a <= regs[bus.o_rd_addr_a];
            bus.i_rd_data_b <= regs[bus.o_rd_addr_b];
        end
    end
    // Multiplier: busy for five cycles after a start, frozen by stall, flushed by clears
    int mcnt = 0;
    logic [63:0] mres = '0;
    assign bus.i_mult_busy = mcnt != 0;
    always @(posedge i_clk) begin
        if (i_reset || bus.i_clear_from_writeback || (!bus.i_data_stall && bus.i_clear_from_alu)) mcnt <= 0;
        else if (!bus.i_data_stall) begin
            if (bus.o_cc_satisfied) begin
                mcnt <= 5;
                mres <= 64'(bus.o_rm) * 64'(bus.o_rs) + {bus.o_rh, bus.o_rn};
            end else if (mcnt != 0) mcnt <= mcnt - 1;
        end
    end
    // Reference model: one in-flight instruction described by its age in advancing cycles since accept
    logic m_active = 1'b0;
    int m_k = 0;
    logic m_acc = 1'b0;
    logic [5:0] m_rm = '0, m_rs = '0, m_rn = '0, m_rh = '0;
    logic [4:0] exp_op = '0;
    logic [31:0] exp_rm = '0, exp_rs = '0, exp_rn = '0, exp_rh = '0;
    function automatic logic m_accept();
        return !m_active && !i_reset && bus.i_valid && bus.i_cc_satisfied &&
               (bus.i_alu_operation inside {UMLALL, UMLALH, SMLALL, SMLALH}) &&
               !bus.i_clear_from_writeback && !bus.i_clear_from_alu && !bus.i_data_stall;
    endfunction
    function automatic logic m_done();
        return m_active && m_k >= 4 + int'(m_acc) && !bus.i_mult_busy;
    endfunction
    function automatic logic m_issue();
        return m_active && m_k == 3 + int'(m_acc);
    endfunction
    function automatic logic [5:0] m_addr(input logic [5:0] first, input logic [5:0] second);
        return (m_active && m_k == 1) ? first : (m_active && m_k == 2 && m_acc) ? second : 6'd0;
    endfunction
    always @(posedge i_clk) begin
        if (i_reset || bus.i_clear_from_writeback || (!bus.i_data_stall && bus.i_clear_from_alu)) begin
            m_active <= 1'b0;
            exp_op <= '0;
            exp_rm <= '0;
            exp_rs <= '0;
            exp_rn <= '0;
            exp_rh <= '0;
        end else if (!bus.i_data_stall) begin
            if (m_active) begin
                if (m_done()) m_active <= 1'b0;
                m_k <= m_k + 1;
                if (m_k == 2) begin
                    exp_rm <= regs[m_rm];
                    exp_rs <= regs[m_rs];
                    if (!m_acc) begin
                        exp_rn <= '0;
                        exp_rh <= '0;
                    end
                end
                if (m_k == 3 && m_acc) begin
                    exp_rn <= regs[m_rn];
                    exp_rh <= regs[m_rh];
                end
            end else if (m_accept()) begin
                m_active <= 1'b1;
                m_k <= 1;
                m_acc <= bus.i_accumulate;
                m_rm <= bus.i_rm_idx;
                m_rs <= bus.i_rs_idx;
                m_rn <= bus.i_rn_idx;
                m_rh <= bus.i_rh_idx;
                exp_op <= bus.i_alu_operation;
            end
        end
    end
    // Compare every output on the falling edge, with the current inputs applied
    always @(negedge i_clk) begin
        check("busy", bus.o_busy, m_accept() || (m_active && !m_done()));
        check("done", bus.o_done, m_done());
        check("cc_satisfied", bus.o_cc_satisfied, m_issue());
        check("rd_addr_a", bus.o_rd_addr_a, m_addr(m_rm, m_rn));
        check("rd_addr_b", bus.o_rd_addr_b, m_addr(m_rs, m_rh));
        check("alu_op_ff", bus.o_alu_operation_ff, exp_op);
        check("rm", bus.o_rm, exp_rm);
        check("rs", bus.o_rs, exp_rs);
        check("rn", bus.o_rn, exp_rn);
        check("rh", bus.o_rh, exp_rh);
    end
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask
    task automatic offer(input logic [4:0] op, input logic cc, input logic acc,
                         input logic [5:0] rm, input logic [5:0] rs, input logic [5:0] rn, input logic [5:0] rh);
        bus.i_valid = 1'b1;
        bus.i_cc_satisfied = cc;
        bus.i_alu_operation = op;
        bus.i_accumulate = acc;
        bus.i_rm_idx = rm;
        bus.i_rs_idx = rs;
        bus.i_rn_idx = rn;
        bus.i_rh_idx = rh;
        tick(1);
        bus.i_valid = 1'b0;
    endtask
    initial begin
        for (int i = 0; i < PHY_REGS; i++) regs[i] = $urandom;
        regs[0] = 32'h0;
        regs[1] = 32'h1;
        regs[3] = 32'h0001_0000;
        regs[4] = 32'h0000_0002;
        bus.i_clear_from_writeback = 1'b0;
        bus.i_data_stall = 1'b0;
        bus.i_clear_from_alu = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_alu_operation = '0;
        bus.i_cc_satisfied = 1'b0;
        bus.i_accumulate = 1'b0;
        bus.i_rm_idx = '0;
        bus.i_rs_idx = '0;
        bus.i_rn_idx = '0;
        bus.i_rh_idx = '0;
        tick(3);
        i_reset = 1'b0;
        tick(2);
        offer(UMLALL, 1'b1, 1'b0, 6'd3, 6'd4, 6'd7, 6'd8);
        tick(12);
        check("umlall_result", mres, 64'h0000_0000_0002_0000);
        offer(SMLALH, 1'b1, 1'b1, 6'd5, 6'd6, 6'd1, 6'd1);
        tick(14);
        offer(UMLALH, 1'b0, 1'b0, 6'd3, 6'd4, 6'd0, 6'd0);
        offer(MUL, 1'b1, 1'b0, 6'd3, 6'd4, 6'd0, 6'd0);
        tick(3);
        offer(SMLALL, 1'b1, 1'b0, 6'd9, 6'd10, 6'd0, 6'd0);
        bus.i_data_stall = 1'b1;
        tick(3);
        bus.i_data_stall = 1'b0;
        tick(4);
        bus.i_data_stall = 1'b1;
        tick(3);
        bus.i_data_stall = 1'b0;
        tick(10);
        offer(UMLALH, 1'b1, 1'b1, 6'd11, 6'd12, 6'd13, 6'd14);
        tick(2);
        bus.i_clear_from_alu = 1'b1;
        tick(1);
        bus.i_clear_from_alu = 1'b0;
        tick(10);
        offer(SMLALH, 1'b1, 1'b0, 6'd15, 6'd16, 6'd0, 6'd0);
        tick(4);
        bus.i_clear_from_writeback = 1'b1;
        bus.i_data_stall = 1'b1;
        tick(1);
        bus.i_clear_from_writeback = 1'b0;
        bus.i_data_stall = 1'b0;
        tick(10);
        bus.i_valid = 1'b1;
        bus.i_cc_satisfied = 1'b1;
        bus.i_alu_operation = UMLALL;
        bus.i_accumulate = 1'b1;
        tick(30);
        bus.i_valid = 1'b0;
        tick(12);
        for (int c = 0; c < 3000; c++) begin
            i_reset = $urandom_range(99) == 0;
            bus.i_clear_from_writeback = $urandom_range(49) == 0;
            bus.i_clear_from_alu = $urandom_range(49) == 0;
            bus.i_data_stall = $urandom_range(9) == 0;
            bus.i_valid = $urandom_range(1);
            bus.i_cc_satisfied = $urandom_range(4) != 0;
            bus.i_alu_operation = $urandom_range(4) < 3 ? 5'(UMLALL + $urandom_range(3)) : 5'($urandom);
            bus.i_accumulate = $urandom_range(1);
            bus.i_rm_idx = 6'($urandom_range(PHY_REGS - 1));
            bus.i_rs_idx = 6'($urandom_range(PHY_REGS - 1));
            bus.i_rn_idx = 6'($urandom_range(PHY_REGS - 1));
            bus.i_rh_idx = 6'($urandom_range(PHY_REGS - 1));
            tick(1);
        end
        i_reset = 1'b0;
        bus.i_clear_from_writeback = 1'b0;
        bus.i_clear_from_alu = 1'b0;
        bus.i_data_stall = 1'b0;
        bus.i_valid = 1'b0;
        tick(15);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
